// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the HPS-facing PIO blocks: register offsets and edge-capture modes.
package soc_system_pio_pkg;

    localparam logic [1:0] PIO_OFF_DATA = 2'd0;
    localparam logic [1:0] PIO_OFF_RSVD = 2'd1;
    localparam logic [1:0] PIO_OFF_MASK = 2'd2;
    localparam logic [1:0] PIO_OFF_EDGE = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    // Returns {fall_en, rise_en}; unknown encodings fall back to rising-edge capture.
    function automatic logic [1:0] edge_enables(input int edge_type);
        if (edge_type == int'(EDGE_FALL)) begin
            return 2'b10;
        end else if (edge_type == int'(EDGE_ANY)) begin
            return 2'b11;
        end
        return 2'b01;
    endfunction

endpackage

// File: rtl/soc_system_pio_in_capture_sync.sv
// Input conditioning for the capture PIO: multi-flop synchronizer, previous-sample register,
// and a prime counter that holds off edge detection until the chain carries real samples.
module pio_sync_edge
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH       = 18,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] sel
);

    localparam int         PRIME_MAX = SYNC_STAGES + 1;
    localparam int         CW        = $clog2(PRIME_MAX + 1);
    localparam logic [1:0] EN        = edge_enables(EDGE_TYPE);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    prime_cnt;
    logic             primed;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev      <= '0;
            prime_cnt <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev <= s;
            if (!primed) begin
                prime_cnt <= prime_cnt + CW'(1);
            end
        end
    end

    assign s      = sync_q[SYNC_STAGES-1];
    assign primed = (prime_cnt == CW'(PRIME_MAX));

    // Until prev has seen a real synchronized sample, s vs prev would show a
    // false rising edge on any input that was already high at reset release.
    assign rise = s & ~prev;
    assign fall = ~s & prev;
    assign sel  = primed ? (({WIDTH{EN[0]}} & rise) | ({WIDTH{EN[1]}} & fall)) : '0;

endmodule

// File: rtl/soc_system_pio_in_capture.sv
// FPGA->HPS input PIO: Avalon-MM slave with synchronized data readback, per-bit edge capture
// (write-one-to-clear), interrupt mask and a registered level interrupt.
module soc_system_pio_in_capture
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH       = 18,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_mux;
    logic             rd_en;
    logic             wr_en;
    logic             wr_mask;
    logic             wr_edge;
    logic             unused_writedata;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .s       (s),
        .sel     (sel)
    );

    assign rd_en   = chipselect & ~read_n;
    assign wr_en   = chipselect & ~write_n;
    assign wr_mask = wr_en && (address == PIO_OFF_MASK);
    assign wr_edge = wr_en && (address == PIO_OFF_EDGE);
    assign wdata   = writedata[WIDTH-1:0];

    // Bits above WIDTH have no register behind them.
    assign unused_writedata = ^writedata;

    always_comb begin
        rd_mux = '0;
        case (address)
            PIO_OFF_DATA: rd_mux = 32'(s);
            PIO_OFF_MASK: rd_mux = 32'(irq_mask);
            PIO_OFF_EDGE: rd_mux = 32'(edge_capture);
            default:      rd_mux = '0;
        endcase
    end

    // A new edge is OR-ed in after the clear so that set wins on a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
            irq          <= 1'b0;
        end else begin
            if (wr_edge) begin
                edge_capture <= (edge_capture & ~wdata) | sel;
            end else begin
                edge_capture <= edge_capture | sel;
            end
            if (wr_mask) begin
                irq_mask <= wdata;
            end
            if (rd_en) begin
                readdata <= rd_mux;
            end
            irq <= |(edge_capture & irq_mask);
        end
    end

endmodule
